coeff_loader: RTL and testbench

Sequencer between the AHB-Lite slave register file and the FIR filter controller. When software sets the new-coefficient flag, it walks `coefficient_num` through F0..F3 and pulses `load_coeff` once per coefficient, handshaking on the controller's `modwait`. It then pulses `clear_new_coeff` back to the slave and flags any handshake timeout. It consumes `new_coefficient_set`/`fir_coefficient` and produces `coefficient_num`/`clear_new_coeff`.

---
 rtl/coeff_loader.sv | 156 +++++++++++++++
 tb/tb_coeff_loader.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coeff_loader.sv
// coeff_loader: walks coefficient_num through F0..F3 whenever the slave's
// new-coefficient flag is pending, pulsing load_coeff once per coefficient and
// handshaking on the FIR controller's modwait. After the set (or a handshake
// timeout) it pulses clear_new_coeff back to the slave.
// Optional feature macro: COEFF_LOADER_CHECKSUM_EN adds a mod-2^16 checksum of
// the last loaded set; without it checksum is tied to zero.
module coeff_loader #(
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_coefficient_set,
    input  logic        modwait,
    input  logic [15:0] fir_coefficient,
    output logic [1:0]  coefficient_num,
    output logic        load_coeff,
    output logic        clear_new_coeff,
    output logic        loading,
    output logic        load_err,
    output logic [15:0] checksum
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_WAIT_ACK  = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_CLEAR     = 3'd4;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [2:0] state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic       load_err_q, load_err_d;
    logic       start_set;    // IDLE -> LOAD: a new set begins
    logic       enter_clear;  // any transition into CLEAR

    // Next-state, index, timeout counter and error flag
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        load_err_d  = load_err_q;
        start_set   = 1'b0;
        enter_clear = 1'b0;
        case (state_q)
            S_IDLE: begin
                idx_d = 2'd0;
                // A pending set waits until the controller is idle.
                if (new_coefficient_set && !modwait) begin
                    state_d    = S_LOAD;
                    load_err_d = 1'b0;
                    start_set  = 1'b1;
                end
            end
            S_LOAD: begin
                state_d = S_WAIT_ACK;
                cnt_d   = 8'd0;
            end
            S_WAIT_ACK: begin
                if (modwait) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // Abandon the rest of the set but still clear the flag.
                    state_d     = S_CLEAR;
                    load_err_d  = 1'b1;
                    enter_clear = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WAIT_DONE: begin
                // No timeout here: the controller may stay busy indefinitely.
                if (!modwait) begin
                    if (idx_q == 2'd3) begin
                        state_d     = S_CLEAR;
                        enter_clear = 1'b1;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_CLEAR: begin
                state_d = S_IDLE;
                idx_d   = 2'd0;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 2'd0;
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= 2'd0;
            cnt_q      <= 8'd0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            load_err_q <= load_err_d;
        end
    end

`ifdef COEFF_LOADER_CHECKSUM_EN
    logic [15:0] acc_q, acc_d;
    logic [15:0] checksum_q, checksum_d;

    // Accumulate each coefficient as it is loaded; capture the sum on CLEAR entry
    always_comb begin
        acc_d      = acc_q;
        checksum_d = checksum_q;
        if (start_set) begin
            acc_d = 16'h0000;
        end else if (state_q == S_LOAD) begin
            acc_d = acc_q + fir_coefficient;
        end
        if (enter_clear) begin
            checksum_d = acc_q;
        end
    end

    // Checksum registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= 16'h0000;
            checksum_q <= 16'h0000;
        end else begin
            acc_q      <= acc_d;
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    // The coefficient value is only needed for the checksum.
    logic unused_fir;
    logic unused_flags;
    assign unused_fir   = ^fir_coefficient;
    assign unused_flags = start_set ^ enter_clear;
    assign checksum     = 16'h0000;
`endif

    // Moore output decode
    assign coefficient_num = idx_q;
    assign load_coeff      = (state_q == S_LOAD);
    assign clear_new_coeff = (state_q == S_CLEAR);
    assign loading         = (state_q != S_IDLE);
    assign load_err        = load_err_q;

endmodule

// File: tb/tb_coeff_loader.sv
// Testbench for coeff_loader: a behavioural FIR-controller/slave stand-in
// answers each load_coeff with a programmed ack delay and busy length, and a
// per-set model predicts pulse count, indices, busy time, error and checksum.
module tb_coeff_loader;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        new_coefficient_set;
    logic        modwait;
    logic [15:0] fir_coefficient;
    logic [1:0]  coefficient_num;
    logic        load_coeff;
    logic        clear_new_coeff;
    logic        loading;
    logic        load_err;
    logic [15:0] checksum;

    int total = 0;
    int bad   = 0;

    // Current set description used by the controller stand-in and the model
    logic [15:0] set_coef [4];
    int          set_d    [4];   // low cycles before modwait rises
    int          set_b    [4];   // cycles modwait stays high
    int          set_to;         // index whose ack never comes, -1 = none
    int          d_left, b_left;

    coeff_loader #(.TIMEOUT(TIMEOUT)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .new_coefficient_set (new_coefficient_set),
        .modwait             (modwait),
        .fir_coefficient     (fir_coefficient),
        .coefficient_num     (coefficient_num),
        .load_coeff          (load_coeff),
        .clear_new_coeff     (clear_new_coeff),
        .loading             (loading),
        .load_err            (load_err),
        .checksum            (checksum)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Controller + slave stand-in: decides modwait and fir_coefficient for this cycle
    task automatic ctl_update();
        if (load_coeff) begin
            if (int'(coefficient_num) == set_to) begin
                d_left = 100000;
                b_left = 0;
            end else begin
                d_left = set_d[coefficient_num];
                b_left = set_b[coefficient_num];
            end
            modwait = 1'b0;
        end else if (d_left > 0) begin
            modwait = 1'b0;
            d_left--;
        end else if (b_left > 0) begin
            modwait = 1'b1;
            b_left--;
        end else begin
            modwait = 1'b0;
        end
        fir_coefficient = set_coef[coefficient_num];
    endtask

    task automatic set_uniform(input int d, input int b);
        for (int i = 0; i < 4; i++) begin
            set_d[i] = d;
            set_b[i] = b;
        end
        set_to = -1;
    endtask

    // Raise the flag and run one whole set, checking it against the model
    task automatic run_set(input string name);
        int          k, exp_load, n_loading, n_clear;
        logic [15:0] exp_sum;
        logic        exp_err;
        bit          done, idx_ok;
        int          idxq[$];

        k       = (set_to < 0) ? 4 : set_to + 1;
        exp_err = (set_to >= 0);
        exp_load = 1;
        exp_sum  = 16'h0000;
        for (int i = 0; i < k; i++) begin
            if (i == set_to) exp_load += 1 + TIMEOUT;
            else             exp_load += 1 + (set_d[i] + 1) + set_b[i];
`ifdef COEFF_LOADER_CHECKSUM_EN
            exp_sum = 16'((32'(exp_sum) + 32'(set_coef[i])) % 65536);
`endif
        end

        d_left = 0;
        b_left = 0;
        modwait = 1'b0;
        new_coefficient_set = 1'b1;
        fir_coefficient = set_coef[0];
        n_loading = 0;
        n_clear   = 0;
        done      = 0;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            step();
            if (cyc == 0) begin
                total++;
                if (load_coeff !== 1'b1 || loading !== 1'b1 || coefficient_num !== 2'd0) begin
                    bad++;
                    $display("FAIL %s start: load_coeff=%b loading=%b num=%0d, want 1 1 0",
                             name, load_coeff, loading, coefficient_num);
                end
            end
            if (loading) n_loading++;
            else         done = 1;
            if (load_coeff) begin
                if (idxq.size() == 0) begin
                    total++;
                    if (load_err !== 1'b0) begin
                        bad++;
                        $display("FAIL %s err_clear_on_load: got %b want 0", name, load_err);
                    end
                end
                idxq.push_back(int'(coefficient_num));
            end
            if (clear_new_coeff) begin
                n_clear++;
                total++;
                if (load_err !== exp_err) begin
                    bad++;
                    $display("FAIL %s err_at_clear: got %b want %b", name, load_err, exp_err);
                end
                new_coefficient_set = 1'b0;
            end
            ctl_update();
        end
        d_left = 0;
        b_left = 0;
        modwait = 1'b0;

        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s finish: FSM still busy after 2000 cycles, want return to idle", name);
        end
        total++;
        if (n_loading != exp_load) begin
            bad++;
            $display("FAIL %s loading_cycles: got %0d want %0d", name, n_loading, exp_load);
        end
        total++;
        if (n_clear != 1) begin
            bad++;
            $display("FAIL %s clear_pulses: got %0d want 1", name, n_clear);
        end
        idx_ok = (idxq.size() == k);
        for (int i = 0; i < idxq.size(); i++) if (idxq[i] != i) idx_ok = 0;
        total++;
        if (!idx_ok) begin
            bad++;
            $display("FAIL %s load_indices: got %0d pulses %p want 0..%0d", name, idxq.size(), idxq, k - 1);
        end
        total++;
        if (checksum !== exp_sum) begin
            bad++;
            $display("FAIL %s checksum: got %h want %h", name, checksum, exp_sum);
        end
        total++;
        if (load_err !== exp_err) begin
            bad++;
            $display("FAIL %s err_after: got %b want %b", name, load_err, exp_err);
        end
        $display("set %s: loads=%0d loading=%0d (model %0d) err=%b checksum=%h (model %h)",
                 name, idxq.size(), n_loading, exp_load, load_err, checksum, exp_sum);
    endtask

    task automatic test_reset_state();
        rst = 1'b1;
        new_coefficient_set = 1'b0;
        modwait = 1'b0;
        fir_coefficient = 16'h0000;
        d_left = 0;
        b_left = 0;
        step();
        step();
        total++;
        if ({coefficient_num, load_coeff, clear_new_coeff, loading, load_err, checksum} !== 22'd0) begin
            bad++;
            $display("FAIL reset_state: num=%0d lc=%b clr=%b ld=%b err=%b cs=%h want all 0",
                     coefficient_num, load_coeff, clear_new_coeff, loading, load_err, checksum);
        end
        rst = 1'b0;
        step();
        total++;
        if (loading !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_flag: loading=%b want 0", loading);
        end
    endtask

    task automatic test_zero_wait();
        set_coef[0] = 16'h0001; set_coef[1] = 16'h0002;
        set_coef[2] = 16'h0003; set_coef[3] = 16'h0004;
        set_uniform(0, 1);
        run_set("zero_wait");
    endtask

    task automatic test_busy_start();
        new_coefficient_set = 1'b1;
        modwait = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (loading !== 1'b0 || load_coeff !== 1'b0) begin
                bad++;
                $display("FAIL busy_start_hold: loading=%b load_coeff=%b want 0 0", loading, load_coeff);
            end
        end
        set_uniform(0, 1);
        run_set("busy_start");
    endtask

    task automatic test_timeout();
        set_uniform(0, 1);
        set_to = 1;
        run_set("timeout_idx1");
    endtask

    task automatic test_recover();
        set_uniform(1, 2);
        run_set("recover");
    endtask

    task automatic test_wrap();
        set_coef[0] = 16'hFFFF; set_coef[1] = 16'h0002;
        set_coef[2] = 16'h0000; set_coef[3] = 16'h0000;
        set_uniform(0, 1);
        run_set("wrap");
    endtask

    task automatic test_long_busy();
        set_uniform(0, 1);
        set_b[2] = 20;
        run_set("long_busy");
    endtask

    task automatic test_reset_mid();
        int seen;
        set_uniform(0, 1);
        set_b[2] = 10;
        new_coefficient_set = 1'b1;
        modwait = 1'b0;
        d_left = 0;
        b_left = 0;
        seen = -1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            step();
            if (load_coeff && coefficient_num == 2'd2) seen = cyc;
            ctl_update();
            if (seen >= 0 && cyc == seen + 3) break;
        end
        total++;
        if (seen < 0 || coefficient_num !== 2'd2 || modwait !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_setup: seen=%0d num=%0d modwait=%b want idx 2 busy",
                     seen, coefficient_num, modwait);
        end
        rst = 1'b1;
        step();
        total++;
        if ({coefficient_num, load_coeff, clear_new_coeff, loading, load_err, checksum} !== 22'd0) begin
            bad++;
            $display("FAIL reset_mid_outputs: num=%0d lc=%b clr=%b ld=%b err=%b cs=%h want all 0",
                     coefficient_num, load_coeff, clear_new_coeff, loading, load_err, checksum);
        end
        rst = 1'b0;
        modwait = 1'b0;
        d_left = 0;
        b_left = 0;
        set_b[2] = 1;
        run_set("after_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 4; i++) begin
                set_coef[i] = 16'($urandom);
                set_d[i]    = int'($urandom_range(0, TIMEOUT - 1));
                set_b[i]    = int'($urandom_range(1, 6));
            end
            set_to = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_set($sformatf("random%0d", n));
        end
    endtask

    initial begin
        test_reset_state();
        test_zero_wait();
        test_busy_start();
        test_timeout();
        test_recover();
        test_wrap();
        test_long_busy();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
